sccb_slave_regs: RTL and testbench

SCCB responder (camera side) that decodes 3-phase writes, 2-phase writes and 2-phase reads from an SCCB master and backs them with an internal 8-bit register file. Sits behind the pad logic as a behavioural/FPGA stand-in for an OV-series sensor. The configuration initiator and SCCB master can be exercised end to end against it, and sensor-style register banks can be emulated on FPGA.

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_bus_monitor.sv | 40 ++++
 rtl/sccb_slave_regs.sv | 154 +++++++++++++++
 tb/tb_sccb_slave_regs.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM encoding, phase framing constants and default IDs for the SCCB responder
package sccb_pkg;

    localparam int         SCCB_PHASE_BITS = 9;
    localparam logic [3:0] SCCB_LAST_BIT   = 4'(SCCB_PHASE_BITS - 1);
    localparam logic [3:0] SCCB_BYTE_LAST  = 4'd7;
    localparam logic [7:0] SCCB_DEF_WR_ID  = 8'h60;
    localparam logic [7:0] SCCB_DEF_RD_ID  = 8'h61;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ID     = 6'b000010,
        S_SUB    = 6'b000100,
        S_WDATA  = 6'b001000,
        S_RDATA  = 6'b010000,
        S_IGNORE = 6'b100000
    } sccb_state_e;

    function automatic logic [7:0] sccb_rd_id(input logic [7:0] wr_id);
        return wr_id | 8'h01;
    endfunction

endpackage

// File: rtl/sccb_bus_monitor.sv
// sccb_bus_monitor: synchronizes SIOC/SIOD and flags START, STOP, bit-sample and drive-update events
module sccb_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic sioc_i,
    input  logic siod_i,
    output logic start_evt,
    output logic stop_evt,
    output logic bit_smp,
    output logic drv_upd,
    output logic sda_s
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_s;
    logic       scl_h;
    logic       sda_h;

    // two sync stages plus a history stage per line; reset to idle-high so no event fires on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], sioc_i};
            sda_q <= {sda_q[1:0], siod_i};
        end
    end

    assign scl_s     = scl_q[1];
    assign scl_h     = scl_q[2];
    assign sda_s     = sda_q[1];
    assign sda_h     = sda_q[2];
    assign start_evt = scl_s & sda_h & ~sda_s;
    assign stop_evt  = scl_s & ~sda_h & sda_s;
    assign bit_smp   = scl_s & ~scl_h;
    assign drv_upd   = ~scl_s & scl_h;

endmodule

// File: rtl/sccb_slave_regs.sv
// sccb_slave_regs: SCCB camera-side responder with an 8-bit register file; SCCB_SLV_ACK_EN enables ACK drive on bit 8
module sccb_slave_regs
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR = SCCB_DEF_WR_ID,
    parameter int unsigned REG_NUM  = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       busy,
    output logic       cfg_wr_valid,
    output logic [7:0] cfg_wr_addr,
    output logic [7:0] cfg_wr_data
);

    localparam logic [7:0] RD_ID = sccb_rd_id(DEV_ADDR);

    logic        start_evt;
    logic        stop_evt;
    logic        bit_smp;
    logic        drv_upd;
    logic        sda_s;

    sccb_state_e state_q, state_d, phase_next;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  sub_addr_q, sub_addr_d;
    logic        oe_q, oe_d;
    logic        wr_valid_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  regs_q [REG_NUM];

    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;
    logic        last;
    logic        byte_end;
    logic        sub_in_range;
    logic        rd_drv;
    logic        ack_drv;
    logic        wr_en;

    sccb_bus_monitor u_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .sioc_i    (sioc_i),
        .siod_i    (siod_i),
        .start_evt (start_evt),
        .stop_evt  (stop_evt),
        .bit_smp   (bit_smp),
        .drv_upd   (drv_upd),
        .sda_s     (sda_s)
    );

    assign byte_in      = {shift_q[6:0], sda_s};
    assign last         = cnt_q == SCCB_LAST_BIT;
    assign byte_end     = cnt_q == SCCB_BYTE_LAST;
    assign sub_in_range = 32'(sub_addr_q) < REG_NUM;
    assign rd_byte      = sub_in_range ? regs_q[sub_addr_q] : 8'h00;
    // ~cnt selects bit 7-cnt, so data goes out MSB first; bit 8 stays released for the master NA
    assign rd_drv       = (state_q == S_RDATA) & ~last & ~rd_byte[~cnt_q[2:0]];

`ifdef SCCB_SLV_ACK_EN
    assign ack_drv = last & (((state_q == S_ID) & ((shift_q == DEV_ADDR) | (shift_q == RD_ID)))
                             | (state_q == S_SUB) | (state_q == S_WDATA));
`else
    assign ack_drv = 1'b0;
`endif

    // phase successor taken when the ACK/don't-care bit has been sampled; the ID byte is complete in shift_q
    always_comb begin
        phase_next = (state_q == S_ID)  ? ((shift_q == DEV_ADDR) ? S_SUB :
                                           (shift_q == RD_ID)    ? S_RDATA : S_IGNORE) :
                     (state_q == S_SUB) ? S_WDATA : S_IGNORE;
    end

    // bus protocol: START/STOP override bit handling, samples on SCL rise, drive changes on SCL fall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sub_addr_d = sub_addr_q;
        oe_d       = oe_q;
        wr_en      = 1'b0;
        if (stop_evt) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (start_evt) begin
            state_d = S_ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (state_q != S_IDLE && bit_smp) begin
            cnt_d      = last ? 4'd0 : cnt_q + 4'd1;
            shift_d    = last ? shift_q : byte_in;
            sub_addr_d = (state_q == S_SUB && byte_end) ? byte_in : sub_addr_q;
            wr_en      = (state_q == S_WDATA) & byte_end & sub_in_range;
            state_d    = last ? phase_next : state_q;
        end else if (state_q != S_IDLE && drv_upd) begin
            oe_d = rd_drv | ack_drv;
        end
    end

    // protocol state, pointer and pin drive registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            sub_addr_q <= 8'h00;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sub_addr_q <= sub_addr_d;
            oe_q       <= oe_d;
        end
    end

    // commit strobe and the last committed address/data, held until the next commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
        end else begin
            wr_valid_q <= wr_en;
            if (wr_en) begin
                wr_addr_q <= sub_addr_q;
                wr_data_q <= byte_in;
            end
        end
    end

    // register file, written only by SCCB data phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= 8'h00;
        end else if (wr_en) begin
            regs_q[sub_addr_q] <= byte_in;
        end
    end

    assign siod_oe      = oe_q;
    assign busy         = state_q != S_IDLE;
    assign cfg_wr_valid = wr_valid_q;
    assign cfg_wr_addr  = wr_addr_q;
    assign cfg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_sccb_slave_regs.sv
// tb_sccb_slave_regs: directed SCCB master transactions against sccb_slave_regs with hand-computed expectations
module tb_sccb_slave_regs;
    import sccb_pkg::*;

`ifdef SCCB_SLV_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       siod_oe;
    logic       busy;
    logic       cfg_wr_valid;
    logic [7:0] cfg_wr_addr;
    logic [7:0] cfg_wr_data;

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic       oe_seen = 1'b0;

    logic [7:0] rx;
    logic       a0, a1, a2;

    assign sda_line = sda_m & ~siod_oe;

    always #5 clk = ~clk;

    sccb_slave_regs #(.DEV_ADDR(8'h60), .REG_NUM(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sioc_i       (scl_m),
        .siod_i       (sda_line),
        .siod_oe      (siod_oe),
        .busy         (busy),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data)
    );

    always @(negedge clk) begin
        if (cfg_wr_valid) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = cfg_wr_addr;
            last_data = cfg_wr_data;
        end
        if (siod_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (5) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic bit_c(input logic b, output logic r);
        sda_m = b; q();
        scl_m = 1'b1; q();
        r = sda_line; q();
        scl_m = 1'b0; q();
    endtask

    task automatic phase(input logic [7:0] tx, output logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_c(tx[i], r);
            d[i] = r;
        end
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        ack = siod_oe; q();
        scl_m = 1'b0; q();
    endtask

    task automatic write3(input logic [7:0] sub, input logic [7:0] data);
        logic [7:0] d;
        logic       a;
        start_c();
        phase(8'h60, d, a);
        phase(sub, d, a);
        phase(data, d, a);
        stop_c();
    endtask

    task automatic set_ptr(input logic [7:0] sub);
        logic [7:0] d;
        logic       a;
        start_c();
        phase(8'h60, d, a);
        phase(sub, d, a);
        stop_c();
    endtask

    task automatic read1(output logic [7:0] d, output logic rel);
        logic [7:0] dd;
        logic       a;
        start_c();
        phase(SCCB_DEF_RD_ID, dd, a);
        phase(8'hFF, d, rel);
        stop_c();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_oe", 32'(siod_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(cfg_wr_valid), 32'd0);
        chk("rst_addr", 32'(cfg_wr_addr), 32'h00);
        chk("rst_data", 32'(cfg_wr_data), 32'h00);
        rst_n = 1'b1;
        q();

        oe_seen = 1'b0;
        start_c();
        phase(8'h60, rx, a0);
        chk("wr_busy", 32'(busy), 32'd1);
        phase(8'h12, rx, a1);
        phase(8'hA5, rx, a2);
        stop_c();
        chk("wr_ack_id", 32'(a0), 32'(ACK));
        chk("wr_ack_sub", 32'(a1), 32'(ACK));
        chk("wr_ack_data", 32'(a2), 32'(ACK));
        chk("wr_cnt1", 32'(wr_cnt), 32'd1);
        chk("wr_addr", 32'(last_addr), 32'h12);
        chk("wr_data", 32'(last_data), 32'hA5);
        chk("wr_oe_seen", 32'(oe_seen), 32'(ACK));
        chk("wr_idle", 32'(busy), 32'd0);

        read1(rx, a0);
        chk("rd_persist", 32'(rx), 32'hA5);
        chk("rd_release", 32'(a0), 32'd0);

        write3(8'h7F, 8'h3C);
        chk("wr_cnt2", 32'(wr_cnt), 32'd2);
        chk("wr2_addr", 32'(last_addr), 32'h7F);
        chk("wr2_data", 32'(last_data), 32'h3C);
        set_ptr(8'h12);
        read1(rx, a0);
        chk("rd_12", 32'(rx), 32'hA5);
        set_ptr(8'h7F);
        read1(rx, a0);
        chk("rd_7f", 32'(rx), 32'h3C);

        oe_seen = 1'b0;
        start_c();
        phase(8'h42, rx, a0);
        chk("fid_busy", 32'(busy), 32'd1);
        phase(8'h12, rx, a1);
        phase(8'h34, rx, a2);
        chk("fid_busy2", 32'(busy), 32'd1);
        stop_c();
        chk("fid_ack", 32'(a0), 32'd0);
        chk("fid_oe_seen", 32'(oe_seen), 32'd0);
        chk("fid_cnt", 32'(wr_cnt), 32'd2);
        chk("fid_idle", 32'(busy), 32'd0);

        start_c();
        phase(8'h60, rx, a0);
        phase(8'h07, rx, a0);
        start_c();
        phase(SCCB_DEF_RD_ID, rx, a0);
        chk("rs_ack", 32'(a0), 32'(ACK));
        phase(8'hFF, rx, a1);
        stop_c();
        chk("rs_data", 32'(rx), 32'h00);
        chk("rs_release", 32'(a1), 32'd0);

        start_c();
        phase(8'h60, rx, a0);
        phase(8'h20, rx, a0);
        bit_c(1'b0, a0);
        bit_c(1'b1, a0);
        bit_c(1'b1, a0);
        bit_c(1'b1, a0);
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ab_busy_2clk", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ab_busy_3clk", 32'(busy), 32'd0);
        chk("ab_oe", 32'(siod_oe), 32'd0);
        q();
        chk("ab_cnt", 32'(wr_cnt), 32'd2);
        set_ptr(8'h20);
        read1(rx, a0);
        chk("ab_reg20", 32'(rx), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
